// File: rtl/seq_ram_loader_pkg.sv
// Shared types and defaults for the sequencer RAM loader.
// Holds the FSM state encoding, default RAM geometry and checksum width.
// No logic here; imported by seq_ram_loader and seq_ram_byte_packer.
package seq_ram_loader_pkg;

  localparam int DEF_ADDR_W = 9;    // sequencer RAM word-address width
  localparam int DEF_DEPTH  = 512;  // RAM depth in 32-bit words
  localparam int CSUM_W     = 32;   // write/read checksum width (carry discarded)

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VREAD  = 3'd3,
    ST_VDRAIN = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/seq_ram_byte_packer.sv
// Purpose: packs a little-endian byte stream into 32-bit words (first byte -> [7:0]).
// Latency: word_cpl_o fires combinationally with the 4th byte; the full word is on word_dat_o next cycle.
// Backpressure: none of its own; the parent gates byte_vld_i with its ready.
// Ports: clk/reset_n; clr_i discards any partial word; byte_vld_i/byte_dat_i accepted byte;
//        word_dat_o packed word; word_cpl_o high on the cycle the 4th byte is accepted.
module seq_ram_byte_packer
  import seq_ram_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic [31:0] word_dat_o,
  output logic        word_cpl_o
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (byte_vld_i) begin
      word_q[{cnt_q, 3'b000} +: 8] <= byte_dat_i;
      cnt_q                        <= cnt_q + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  assign word_cpl_o = byte_vld_i && (cnt_q == 2'd3);
  assign word_dat_o = word_q;

endmodule

// File: rtl/seq_ram_loader.sv
// Purpose: streams bytes into a sequencer RAM as 32-bit words starting at base_addr, wrapping mod DEPTH.
// Latency: 5 cycles per word with a continuous stream (4 FILL + 1 WRITE), plus verify pass and DONE.
// Backpressure: in_ready high only in FILL; in_valid gaps simply stall FILL.
// Config: define SEQ_RAM_LOADER_VERIFY_EN to read the block back and compare checksums (VREAD/VDRAIN).
// Ports: clk, reset_n (async, active-low); start/base_addr/word_count load request;
//        in_data/in_valid/in_ready byte stream; ram_* RAM slave port; busy/done/error status.
module seq_ram_loader
  import seq_ram_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_writedata,
  output logic [3:0]        ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic              ram_clken,
  input  logic [31:0]       ram_readdata,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     idx_q, idx_d;

  logic                fill_rdy;
  logic                start_acc;
  logic [31:0]         word_dat;
  logic                word_cpl;
  logic [ADDR_W:0]     wc_clamped;
  logic [ADDR_W:0]     idx_inc;
  logic [ADDR_W:0]     addr_sum;
  logic [ADDR_W:0]     addr_wrap;

  // Kept outside the FSM process: the packer strobe depends on it and feeds back into next-state.
  assign fill_rdy   = (state_q == ST_FILL);
  assign in_ready   = fill_rdy;
  assign start_acc  = (state_q == ST_IDLE) && start;
  assign busy       = (state_q != ST_IDLE);
  assign ram_clken  = reset_n;

  assign wc_clamped = (word_count > DEPTH_W) ? DEPTH_W : word_count;
  assign idx_inc    = idx_q + ONE_W;
  // base_q < DEPTH and idx_q < DEPTH, so a single conditional subtract wraps correctly.
  assign addr_sum   = {1'b0, base_q} + idx_q;
  assign addr_wrap  = (addr_sum >= DEPTH_W) ? (addr_sum - DEPTH_W) : addr_sum;

  seq_ram_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (start_acc),
    .byte_vld_i (in_valid && fill_rdy),
    .byte_dat_i (in_data),
    .word_dat_o (word_dat),
    .word_cpl_o (word_cpl)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    count_d        = count_q;
    idx_d          = idx_q;
    done           = 1'b0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_byteenable = 4'h0;
    ram_address    = '0;
    ram_writedata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          count_d = wc_clamped;
          idx_d   = '0;
          state_d = (wc_clamped == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (word_cpl) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        ram_byteenable = 4'hF;
        ram_address    = addr_wrap[ADDR_W-1:0];
        ram_writedata  = word_dat;
        idx_d          = idx_inc;
        if (idx_inc == count_q) begin
`ifdef SEQ_RAM_LOADER_VERIFY_EN
          idx_d   = '0;
          state_d = ST_VREAD;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_FILL;
        end
      end
`ifdef SEQ_RAM_LOADER_VERIFY_EN
      ST_VREAD: begin
        ram_chipselect = 1'b1;
        ram_byteenable = 4'hF;
        ram_address    = addr_wrap[ADDR_W-1:0];
        idx_d          = idx_inc;
        if (idx_inc == count_q) state_d = ST_VDRAIN;
      end
      ST_VDRAIN: begin
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SEQ_RAM_LOADER_VERIFY_EN
  logic [CSUM_W-1:0] wr_sum_q, wr_sum_d;
  logic [CSUM_W-1:0] rd_sum_q, rd_sum_d;
  logic              rd_pend_q, rd_pend_d;
  logic              error_q, error_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_sum_q  <= '0;
      rd_sum_q  <= '0;
      rd_pend_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_sum_q  <= wr_sum_d;
      rd_sum_q  <= rd_sum_d;
      rd_pend_q <= rd_pend_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    wr_sum_d  = wr_sum_q;
    rd_sum_d  = rd_sum_q;
    rd_pend_d = (state_q == ST_VREAD);  // read data returns the cycle after the address
    error_d   = error_q;
    if (start_acc) begin
      wr_sum_d = '0;
      rd_sum_d = '0;
      error_d  = 1'b0;
    end
    if (state_q == ST_WRITE) wr_sum_d = wr_sum_q + word_dat;
    if (rd_pend_q)           rd_sum_d = rd_sum_q + ram_readdata;
    // Compare against the sum including the drained word so error is already valid while done pulses.
    if (state_q == ST_VDRAIN) error_d = (rd_sum_d != wr_sum_q);
  end

  assign error = error_q;
`else
  logic [31:0] unused_rdata;
  assign unused_rdata = ram_readdata;
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_ram_loader.sv
// Bench for seq_ram_loader: behavioural RAM, write/read-address scoreboard, latency and error checks.
// Follows SEQ_RAM_LOADER_VERIFY_EN the same way as the design.
module tb_seq_ram_loader;

`ifdef SEQ_RAM_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  word_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  ram_address;
  logic [31:0] ram_writedata;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect;
  logic        ram_write;
  logic        ram_clken;
  logic [31:0] ram_readdata;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  seq_ram_loader dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ram_address    (ram_address),
    .ram_writedata  (ram_writedata),
    .ram_byteenable (ram_byteenable),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // RAM model: registered read, optional bit-0 corruption of word 1 on read.
  logic [31:0] mem [0:511];
  bit          corrupt = 1'b0;
  always @(posedge clk) begin
    if (ram_chipselect && ram_write) mem[ram_address] <= ram_writedata;
    if (ram_chipselect && !ram_write)
      ram_readdata <= mem[ram_address] ^ ((corrupt && ram_address == 9'd1) ? 32'd1 : 32'd0);
  end

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wr_q [$];
  logic [8:0] rd_q [$];

  int   cyc = 0;
  int   t0 = 0;
  int   done_lat = 0;
  bit   done_seen = 1'b0;
  logic err_at_done = 1'b0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (start && !busy) t0 = cyc;
      if (ram_chipselect && ram_write) begin
        wr_cnt++;
        chk("wr_in_ready", {63'd0, in_ready}, 64'd0);
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", {55'd0, ram_address}, 64'h1ff_ffff);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", {55'd0, ram_address}, {55'd0, e.addr});
          chk("wr_data", {32'd0, ram_writedata}, {32'd0, e.data});
        end
      end
      if (ram_chipselect && !ram_write) begin
        rd_cnt++;
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", {55'd0, ram_address}, 64'h1ff_ffff);
        end else begin
          logic [8:0] ea;
          ea = rd_q.pop_front();
          chk("rd_addr", {55'd0, ram_address}, {55'd0, ea});
        end
      end
      if (done) begin
        done_seen   = 1'b1;
        done_lat    = cyc - t0;
        err_at_done = error;
      end
    end
  end

  function automatic logic [63:0] outs();
    return {12'd0, in_ready, busy, done, error, ram_chipselect, ram_write, ram_clken,
            ram_byteenable, ram_address, ram_writedata};
  endfunction

  task automatic send_bytes(input logic [7:0] b[$], input bit gap);
    bit acc;
    foreach (b[k]) begin
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_data  = b[k];
      in_valid = 1'b1;
      acc      = 1'b0;
      for (int n = 0; n < 20 && !acc; n++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      if (!acc) chk("byte_timeout", 64'd0, 64'd1);
    end
    in_valid = 1'b0;
  endtask

  // Pushes expectations, issues start, streams bytes (byte i = first + i*step), then checks completion.
  task automatic run_load(input int base, input int cnt, input logic [7:0] first,
                          input logic [7:0] step, input bit gap, input bit corr);
    logic [7:0] bytes [$];
    int  eff, exp_lat, wr0, rd0;
    bit  exp_err;
    logic [7:0] bv;
    eff = (cnt > 512) ? 512 : cnt;
    exp_err = 1'b0;
    bv = first;
    for (int i = 0; i < eff * 4; i++) begin
      bytes.push_back(bv);
      bv = bv + step;
    end
    for (int w = 0; w < eff; w++) begin
      wr_t e;
      e.addr = 9'((base + w) % 512);
      e.data = {bytes[4*w+3], bytes[4*w+2], bytes[4*w+1], bytes[4*w]};
      wr_q.push_back(e);
      if (VERIFY) rd_q.push_back(e.addr);
      if (corr && VERIFY && e.addr == 9'd1) exp_err = 1'b1;
    end
    corrupt   = corr;
    done_seen = 1'b0;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = 9'(base);
    word_count = 10'(cnt);
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_clr_on_start", {63'd0, error}, 64'd0);
    if (eff > 0) send_bytes(bytes, gap);
    for (int n = 0; n < 5000 && !done_seen; n++) @(posedge clk);
    if (!done_seen) chk("done_timeout", 64'd0, 64'd1);
    if (eff == 0)    exp_lat = 1;
    else if (VERIFY) exp_lat = 6 * eff + 2;
    else             exp_lat = 5 * eff + 1;
    if (!gap) chk("done_lat", 64'(done_lat), 64'(exp_lat));
    chk("err_at_done", {63'd0, err_at_done}, {63'd0, exp_err});
    chk("wr_count", 64'(wr_cnt - wr0), 64'(eff));
    chk("rd_count", 64'(rd_cnt - rd0), VERIFY ? 64'(eff) : 64'd0);
    chk("sb_empty", 64'(wr_q.size() + rd_q.size()), 64'd0);
  endtask

  logic [7:0] part [$];

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    #1;
    chk("rst_outs", outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("clken_after_rst", {63'd0, ram_clken}, 64'd1);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // Basic load: 0x04030201@0, 0x08070605@1.
    run_load(0, 2, 8'h01, 8'h01, 1'b0, 1'b0);
    // Wrap: writes and reads at 511 then 0.
    run_load(511, 2, 8'h40, 8'h01, 1'b0, 1'b0);
    // Stall: in_valid toggling, same bytes as the basic load.
    run_load(0, 2, 8'h01, 8'h01, 1'b1, 1'b0);
    chk("mem0_stall", {32'd0, mem[0]}, 64'h0403_0201);
    chk("mem1_stall", {32'd0, mem[1]}, 64'h0807_0605);
    // Corruption on readback of word 1; error must stay until next start.
    run_load(0, 2, 8'h10, 8'h03, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("err_sticky", {63'd0, error}, {63'd0, VERIFY});
    // Zero-count load: DONE right after the start cycle, no RAM access; also clears error.
    run_load(3, 0, 8'h00, 8'h01, 1'b0, 1'b0);

    // Reset in the middle of a word.
    @(posedge clk); #1;
    start      = 1'b1;
    base_addr  = 9'd5;
    word_count = 10'd1;
    @(posedge clk); #1;
    start = 1'b0;
    part  = {8'h11, 8'h22};
    send_bytes(part, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", outs(), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    run_load(5, 1, 8'hAA, 8'h11, 1'b0, 1'b0);
    chk("mem5_after_rst", {32'd0, mem[5]}, 64'hDDCC_BBAA);

    // Oversized count clamps to the RAM depth.
    run_load(0, 600, 8'h00, 8'h01, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
